// File: rtl/song_playback_ctrl.sv
// Playback sequencer for one song slot: button pulses -> play/song_done/reset_player, ms timebase, elapsed time, song select.
// Latency: every output is registered; a button pulse in cycle N shows on the outputs in cycle N+1.
// Backpressure: none; button pulses are single-cycle events and are always accepted (lower priority ones dropped).
module song_playback_ctrl #(
    parameter logic [15:0] TICKS_PER_MS = 16'd50000,
    parameter logic [19:0] SONG_LEN_MS  = 20'd30000,
    parameter logic [2:0]  NUM_SONGS    = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_play_pause,
    input  logic        btn_next,
    input  logic        btn_restart,
    output logic        play,
    output logic        song_done,
    output logic        reset_player,
    output logic [2:0]  song_sel,
    output logic [19:0] elapsed_ms,
    output logic        ms_tick
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] presc;
    logic [15:0] presc_nxt;
    logic [19:0] elapsed_nxt;
    logic [2:0]  sel_nxt;
    logic        rp_nxt;
    logic        tick_nxt;

    logic        presc_wrap;
    logic [2:0]  sel_inc;
    logic [19:0] elapsed_inc;

    assign presc_wrap  = (presc == TICKS_PER_MS - 16'd1);
    assign sel_inc     = (song_sel == NUM_SONGS - 3'd1) ? 3'd0 : song_sel + 3'd1;
    assign elapsed_inc = elapsed_ms + 20'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= 16'd0;
            elapsed_ms   <= 20'd0;
            song_sel     <= 3'd0;
            reset_player <= 1'b0;
            ms_tick      <= 1'b0;
            play         <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            presc        <= presc_nxt;
            elapsed_ms   <= elapsed_nxt;
            song_sel     <= sel_nxt;
            reset_player <= rp_nxt;
            ms_tick      <= tick_nxt;
            play         <= (state_nxt == PLAYING);
            song_done    <= (state_nxt == DONE);
        end
    end

    // Buttons are mutually exclusive by priority; the prescaler only advances on a button-free PLAYING cycle.
    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        elapsed_nxt = elapsed_ms;
        sel_nxt     = song_sel;
        rp_nxt      = 1'b0;
        tick_nxt    = 1'b0;

        if (btn_restart) begin
            presc_nxt   = 16'd0;
            elapsed_nxt = 20'd0;
            rp_nxt      = 1'b1;
            if (state == PAUSED || state == DONE) begin
                state_nxt = IDLE;
            end
        end else if (btn_next) begin
            sel_nxt     = sel_inc;
            presc_nxt   = 16'd0;
            elapsed_nxt = 20'd0;
            rp_nxt      = 1'b1;
            if (state != PLAYING) begin
                state_nxt = IDLE;
            end
        end else if (btn_play_pause) begin
            case (state)
                IDLE:    state_nxt = PLAYING;
                PLAYING: state_nxt = PAUSED;
                PAUSED:  state_nxt = PLAYING;
                DONE: begin
                    state_nxt   = PLAYING;
                    presc_nxt   = 16'd0;
                    elapsed_nxt = 20'd0;
                    rp_nxt      = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state == PLAYING) begin
            if (presc_wrap) begin
                presc_nxt = 16'd0;
                tick_nxt  = 1'b1;
                // Clamp so elapsed_ms can never run past the song length.
                if (elapsed_inc >= SONG_LEN_MS) begin
                    elapsed_nxt = SONG_LEN_MS;
                    state_nxt   = DONE;
                end else begin
                    elapsed_nxt = elapsed_inc;
                end
            end else begin
                presc_nxt = presc + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_song_playback_ctrl.sv
// Bench for song_playback_ctrl: a played-cycle model checked every cycle plus directed literal checks.
module tb_song_playback_ctrl;

    localparam int T   = 4;
    localparam int LEN = 5;
    localparam int NS  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_play_pause = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_restart = 1'b0;
    logic        play;
    logic        song_done;
    logic        reset_player;
    logic [2:0]  song_sel;
    logic [19:0] elapsed_ms;
    logic        ms_tick;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: 0 idle, 1 playing, 2 paused, 3 done; time kept as total counted cycles in the song
    int m_state  = 0;
    int m_played = 0;
    int m_sel    = 0;
    int m_rp     = 0;
    int m_tick   = 0;

    song_playback_ctrl #(
        .TICKS_PER_MS(16'd4),
        .SONG_LEN_MS (20'd5),
        .NUM_SONGS   (3'd3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_play_pause(btn_play_pause),
        .btn_next      (btn_next),
        .btn_restart   (btn_restart),
        .play          (play),
        .song_done     (song_done),
        .reset_player  (reset_player),
        .song_sel      (song_sel),
        .elapsed_ms    (elapsed_ms),
        .ms_tick       (ms_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit pp, input bit nx, input bit rs);
        m_rp   = 0;
        m_tick = 0;
        if (rs) begin
            m_played = 0;
            m_rp     = 1;
            if (m_state == 2 || m_state == 3) m_state = 0;
        end else if (nx) begin
            m_sel    = (m_sel + 1) % NS;
            m_played = 0;
            m_rp     = 1;
            if (m_state != 1) m_state = 0;
        end else if (pp) begin
            if (m_state == 1) begin
                m_state = 2;
            end else begin
                if (m_state == 3) begin
                    m_played = 0;
                    m_rp     = 1;
                end
                m_state = 1;
            end
        end else if (m_state == 1) begin
            m_played++;
            if (m_played % T == 0) m_tick = 1;
            if (m_played / T >= LEN) m_state = 3;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0; m_played = 0; m_sel = 0; m_rp = 0; m_tick = 0;
            end else begin
                model_step(btn_play_pause, btn_next, btn_restart);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cmp_play",    int'(play),         int'(m_state == 1));
                chk("cmp_done",    int'(song_done),    int'(m_state == 3));
                chk("cmp_rp",      int'(reset_player), m_rp);
                chk("cmp_tick",    int'(ms_tick),      m_tick);
                chk("cmp_sel",     int'(song_sel),     m_sel);
                chk("cmp_elapsed", int'(elapsed_ms),   m_played / T);
            end
        end
    end

    // One clock with the given buttons; returns 1 time unit after the capturing edge.
    task automatic cyc(input bit pp, input bit nx, input bit rs);
        btn_play_pause = pp;
        btn_next       = nx;
        btn_restart    = rs;
        @(posedge clk);
        #1;
        btn_play_pause = 1'b0;
        btn_next       = 1'b0;
        btn_restart    = 1'b0;
    endtask

    initial begin
        int ticks;
        int waited;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_play", int'(play), 0);
        chk("rst_elapsed", int'(elapsed_ms), 0);
        rst = 1'b0;
        cyc(0, 0, 0);

        // Full song to DONE
        cyc(1, 0, 0);
        chk("t1_play", int'(play), 1);
        ticks  = 0;
        waited = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(0, 0, 0);
            if (ms_tick) ticks++;
            waited = i;
            if (song_done) break;
        end
        chk("t1_cycles_to_done", waited, 20);
        chk("t1_ticks", ticks, 5);
        chk("t1_elapsed", int'(elapsed_ms), 5);
        repeat (20) cyc(0, 0, 0);
        chk("t1_hold_elapsed", int'(elapsed_ms), 5);
        chk("t1_hold_done", int'(song_done), 1);
        chk("t1_hold_play", int'(play), 0);

        // Play from DONE restarts the same song
        cyc(1, 0, 0);
        chk("t5_rp", int'(reset_player), 1);
        chk("t5_elapsed", int'(elapsed_ms), 0);
        chk("t5_play", int'(play), 1);
        chk("t5_done", int'(song_done), 0);
        chk("t5_sel", int'(song_sel), 0);

        // Pause and resume mid-ms
        repeat (8) cyc(0, 0, 0);
        chk("t2_elapsed2", int'(elapsed_ms), 2);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("t2_paused", int'(play), 0);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0);
            if (ms_tick) ticks++;
        end
        chk("t2_no_ticks", ticks, 0);
        chk("t2_hold", int'(elapsed_ms), 2);
        cyc(1, 0, 0);
        chk("t2_resumed", int'(play), 1);
        waited = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 0, 0);
            waited = i;
            if (ms_tick) break;
        end
        chk("t2_resume_wait", waited, 2);
        chk("t2_elapsed3", int'(elapsed_ms), 3);

        // Pause on the wrap cycle suppresses the tick
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("pw_tick", int'(ms_tick), 0);
        chk("pw_elapsed", int'(elapsed_ms), 3);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("pw_tick_after", int'(ms_tick), 1);
        chk("pw_elapsed4", int'(elapsed_ms), 4);

        // Next x3 while playing
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0);
            chk("t3_sel", int'(song_sel), i % 3);
            chk("t3_rp", int'(reset_player), 1);
            chk("t3_elapsed", int'(elapsed_ms), 0);
            chk("t3_play", int'(play), 1);
        end

        // Coinciding buttons: restart wins
        cyc(0, 1, 0);
        repeat (5) cyc(0, 0, 0);
        chk("t4_pre_elapsed", int'(elapsed_ms), 1);
        cyc(1, 1, 1);
        chk("t4_sel", int'(song_sel), 1);
        chk("t4_elapsed", int'(elapsed_ms), 0);
        chk("t4_play", int'(play), 1);
        chk("t4_rp", int'(reset_player), 1);
        cyc(0, 0, 0);
        chk("t4_rp_low", int'(reset_player), 0);

        // Pause on the final tick beats the move to DONE
        repeat (18) cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("eos_play", int'(play), 0);
        chk("eos_done", int'(song_done), 0);
        chk("eos_elapsed", int'(elapsed_ms), 4);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("eos_done_after", int'(song_done), 1);
        chk("eos_elapsed5", int'(elapsed_ms), 5);

        // Async reset mid-song
        cyc(0, 1, 0);
        chk("t6_sel2", int'(song_sel), 2);
        chk("t6_idle", int'(play), 0);
        cyc(1, 0, 0);
        repeat (12) cyc(0, 0, 0);
        chk("t6_pre_elapsed", int'(elapsed_ms), 3);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_play", int'(play), 0);
        chk("t6_rst_sel", int'(song_sel), 0);
        chk("t6_rst_elapsed", int'(elapsed_ms), 0);
        chk("t6_rst_rp", int'(reset_player), 0);
        chk("t6_rst_tick", int'(ms_tick), 0);
        chk("t6_rst_done", int'(song_done), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 0);
        chk("t6_play", int'(play), 1);
        chk("t6_sel0", int'(song_sel), 0);
        chk("t6_elapsed0", int'(elapsed_ms), 0);
        repeat (6) cyc(0, 0, 0);
        chk("t6_elapsed1", int'(elapsed_ms), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
